// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations after decode and resolves
// RAW hazards as a forward-select per source or a decode stall.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int ALU_AVAIL  = 1,
    parameter int LOAD_AVAIL = 2,
    parameter int RA_W       = 5,
    parameter int WB_BYPASS  = 0,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ID_VALID,
    input  logic [RA_W-1:0] ID_RS1,
    input  logic [RA_W-1:0] ID_RS2,
    input  logic            ID_USE1,
    input  logic            ID_USE2,
    input  logic [RA_W-1:0] ID_RD,
    input  logic            ID_REGWRT,
    input  logic            ID_LOAD,
    input  logic            FLUSH,
    output logic            STALL,
    output logic [SW-1:0]   FWD1_SEL,
    output logic [SW-1:0]   FWD2_SEL,
    output logic [15:0]     STALL_CNT
);
    logic            v  [1:DEPTH];
    logic [RA_W-1:0] rd [1:DEPTH];
    logic            wr [1:DEPTH];
    logic            ld [1:DEPTH];
    int              k1, k2;
    logic            l1, l2, rdy1, rdy2;

    // Scanning oldest to youngest lets the lowest matching stage win.
    always_comb begin
        k1 = 0;
        k2 = 0;
        l1 = 1'b0;
        l2 = 1'b0;
        for (int i = DEPTH; i >= 1; i--) begin
            if (v[i] && wr[i] && rd[i] == ID_RS1 && ID_RS1 != '0 && ID_USE1) begin
                k1 = i;
                l1 = ld[i];
            end
            if (v[i] && wr[i] && rd[i] == ID_RS2 && ID_RS2 != '0 && ID_USE2) begin
                k2 = i;
                l2 = ld[i];
            end
        end
    end

    assign rdy1     = k1 != 0 && k1 >= (l1 ? LOAD_AVAIL : ALU_AVAIL);
    assign rdy2     = k2 != 0 && k2 >= (l2 ? LOAD_AVAIL : ALU_AVAIL);
    assign STALL    = ID_VALID && !FLUSH && ((k1 != 0 && !rdy1) || (k2 != 0 && !rdy2));
    assign FWD1_SEL = (rdy1 && !(WB_BYPASS != 0 && k1 == DEPTH)) ? SW'(k1) : '0;
    assign FWD2_SEL = (rdy2 && !(WB_BYPASS != 0 && k2 == DEPTH)) ? SW'(k2) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 1; i <= DEPTH; i++) begin
                v[i]  <= 1'b0;
                rd[i] <= '0;
                wr[i] <= 1'b0;
                ld[i] <= 1'b0;
            end
            STALL_CNT <= '0;
        end else begin
            v[1]  <= ID_VALID && !STALL && !FLUSH;
            rd[1] <= ID_RD;
            wr[1] <= ID_REGWRT;
            ld[1] <= ID_LOAD;
            for (int i = 2; i <= DEPTH; i++) begin
                v[i]  <= v[i-1];
                rd[i] <= rd[i-1];
                wr[i] <= wr[i-1];
                ld[i] <= ld[i-1];
            end
            if (STALL && STALL_CNT != 16'hFFFF)
                STALL_CNT <= STALL_CNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed load/ALU hazard vectors against three
// configurations (default, write-back bypass, deep slow-load for saturation).
module tb_hazard_scoreboard;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       ID_VALID, ID_USE1, ID_USE2, ID_REGWRT, ID_LOAD, FLUSH;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       stall, stall_bp, stall_sat;
    logic [1:0] fwd1, fwd2, fwd1_bp, fwd2_bp;
    logic [2:0] fwd1_sat, fwd2_sat;
    logic [15:0] cnt, cnt_bp, cnt_sat;
    int         n_tests = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE1(ID_USE1), .ID_USE2(ID_USE2), .ID_RD(ID_RD), .ID_REGWRT(ID_REGWRT),
        .ID_LOAD(ID_LOAD), .FLUSH(FLUSH), .STALL(stall), .FWD1_SEL(fwd1), .FWD2_SEL(fwd2),
        .STALL_CNT(cnt)
    );

    hazard_scoreboard #(.WB_BYPASS(1)) dut_bp (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE1(ID_USE1), .ID_USE2(ID_USE2), .ID_RD(ID_RD), .ID_REGWRT(ID_REGWRT),
        .ID_LOAD(ID_LOAD), .FLUSH(FLUSH), .STALL(stall_bp), .FWD1_SEL(fwd1_bp),
        .FWD2_SEL(fwd2_bp), .STALL_CNT(cnt_bp)
    );

    hazard_scoreboard #(.DEPTH(6), .LOAD_AVAIL(6)) dut_sat (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USE1(ID_USE1), .ID_USE2(ID_USE2), .ID_RD(ID_RD), .ID_REGWRT(ID_REGWRT),
        .ID_LOAD(ID_LOAD), .FLUSH(FLUSH), .STALL(stall_sat), .FWD1_SEL(fwd1_sat),
        .FWD2_SEL(fwd2_sat), .STALL_CNT(cnt_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // valid, rs1, use1, rs2, use2, rd, regwrt, load, flush
    task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] d,
                         input logic w, input logic l, input logic f);
        ID_VALID = v; ID_RS1 = s1; ID_USE1 = u1; ID_RS2 = s2; ID_USE2 = u2;
        ID_RD = d; ID_REGWRT = w; ID_LOAD = l; FLUSH = f;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        check("rst_stall", stall, 0);
        check("rst_fwd1", fwd1, 0);
        check("rst_fwd2", fwd2, 0);
        check("rst_cnt", cnt, 0);

        // add x5 ; add x6,x5,x1
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        check("alu_stall", stall, 0);
        check("alu_fwd1", fwd1, 1);
        check("alu_fwd2", fwd2, 0);
        tick(); idle(3);

        // lw x5 ; add x6,x5,x5 -> one stall then forward from stage 2
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
        check("lu_stall1", stall, 1);
        check("lu_fwd1_wait", fwd1, 0);
        tick();
        check("lu_stall2", stall, 0);
        check("lu_fwd1", fwd1, 2);
        check("lu_fwd2", fwd2, 2);
        check("lu_cnt", cnt, 1);
        tick(); idle(3);
        check("lu_cnt_hold", cnt, 1);

        // add x5 at stage 3 and stage 1, youngest wins; x0 never hazards
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        idle(1);
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        check("young_fwd1", fwd1, 1);
        check("young_stall", stall, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0);
        check("x0_stall", stall, 0);
        check("x0_fwd1", fwd1, 0);
        check("x0_fwd2", fwd2, 0);
        tick(); idle(3);

        // lw x7 ; flushed lw x7,x7 must not enter stage 1
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
        drive(1, 7, 1, 0, 0, 7, 1, 1, 1);
        check("flush_stall", stall, 0);
        tick();
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
        check("flush_bubble_stall", stall, 0);
        check("flush_bubble_fwd", fwd1, 2);
        tick(); idle(3);

        // producer at write-back stage; unused source never forwards
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0); tick();
        idle(2);
        drive(1, 9, 1, 9, 0, 10, 1, 0, 0);
        check("wb_fwd1", fwd1, 3);
        check("wb_bp_fwd1", fwd1_bp, 0);
        check("wb_stall", stall, 0);
        check("nouse_fwd2", fwd2, 0);
        tick(); idle(3);

        // reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        check("mid_stall_on", stall, 1);
        RESET = 1'b1; tick(); RESET = 1'b0; #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_cnt", cnt, 0);
        tick();
        check("mid_rst_after", stall, 0);
        idle(3);

        // slow-load config: self-dependent load stalls 5 of every 6 cycles
        do_reset();
        drive(1, 5, 1, 0, 0, 5, 1, 1, 0);
        check("sat_stall_len", stall_sat, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("sat_stall_run", stall_sat, 1);
            tick();
        end
        check("sat_stall_end", stall_sat, 0);
        check("sat_cnt5", cnt_sat, 5);
        repeat (84000) tick();
        check("sat_cnt", cnt_sat, 16'hFFFF);
        begin
            int n = 0;
            while (!stall_sat && n < 10) begin
                tick();
                n++;
            end
            check("sat_wait_stall", stall_sat, 1);
        end
        RESET = 1'b1; tick(); RESET = 1'b0; #1;
        check("sat_rst_stall", stall_sat, 0);
        check("sat_rst_cnt", cnt_sat, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
